// File: rtl/psimd_lane_pipe.sv
// psimd_lane_pipe: 3-stage (read / execute / writeback) packed-SIMD lane pipeline.
// Optional macro PSIMD_FWD_EN: forward E/W results into R instead of stalling on hazards.
module psimd_lane_pipe #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 16,
  parameter int unsigned NREGS  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             instr,
  output logic                    out_valid,
  output logic [4:0]              out_rd,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic [LANES-1:0]        ovf_flags,
  output logic                    illegal_flag,
  output logic                    busy
);
  localparam int unsigned VW = LANES * LANE_W;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = $clog2(LANES);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADDS = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SUBS = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_MIN  = 4'd8;
  localparam logic [3:0] OP_MAX  = 4'd9;
  localparam logic [3:0] OP_LDI  = 4'd10;
  localparam logic [3:0] OP_CLRF = 4'd11;
  localparam logic [3:0] OP_RSUM = 4'd12;

  localparam logic [CW-1:0]     CNT_LAST = CW'(LANES - 2);
  localparam logic [LANE_W-1:0] SAT_MAX  = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] SAT_MIN  = {1'b1, {(LANE_W-1){1'b0}}};

  function automatic logic op_writes(input logic [3:0] op);
    return ((op >= OP_ADD) && (op <= OP_LDI)) || (op == OP_RSUM);
  endfunction

  function automatic logic op_rs1(input logic [3:0] op);
    return ((op >= OP_ADD) && (op <= OP_MAX)) || (op == OP_RSUM);
  endfunction

  function automatic logic op_rs2(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MAX);
  endfunction

  // Architectural state
  logic [VW-1:0]     rf [NREGS];
  logic              rdy_q;

  // E stage
  logic              e_valid;
  logic [3:0]        e_op;
  logic [AW-1:0]     e_rd;
  logic [VW-1:0]     e_a;
  logic [VW-1:0]     e_b;
  logic [15:0]       e_imm;
  logic [CW-1:0]     e_cnt;
  logic [LANE_W-1:0] rs_acc;

  // W stage bookkeeping beyond the out_* registers
  logic              w_clrf;

  // R stage decode
  logic [3:0]        r_op;
  logic [AW-1:0]     r_rd;
  logic [AW-1:0]     r_rs1;
  logic [AW-1:0]     r_rs2;
  logic [15:0]       r_imm;
  logic [VW-1:0]     r_a;
  logic [VW-1:0]     r_b;

  logic              e_done;
  logic              e_fin;
  logic              e_we;
  logic              rsum_hold;
  logic              hazard;
  logic              accept;

  logic [VW-1:0]     e_res;
  logic [LANES-1:0]  e_ovf;
  logic [CW-1:0]     rs_idx;
  logic [LANE_W-1:0] rs_sum;
  logic [LANE_W-1:0] la [LANES];
  logic [LANE_W-1:0] lb [LANES];
  logic [LANE_W-1:0] rl [LANES];
  logic [LANE_W:0]   sa [LANES];
  logic [LANE_W:0]   sd [LANES];

  assign r_op  = instr[31:28];
  assign r_rd  = instr[27:23];
  assign r_rs1 = instr[22:18];
  assign r_rs2 = instr[17:13];
  assign r_imm = instr[15:0];

  // RSUM stays in E until its last partial sum; E only advances once done
  assign e_done    = (e_op != OP_RSUM) || (e_cnt == CNT_LAST);
  assign e_fin     = e_valid && e_done;
  assign e_we      = op_writes(e_op);
  assign rsum_hold = e_valid && !e_done;

`ifdef PSIMD_FWD_EN
  assign hazard = 1'b0;
`else
  logic e_pend;
  logic w_pend;
  logic hz1;
  logic hz2;
  assign e_pend = e_valid && e_we && (e_rd != '0);
  assign w_pend = out_valid && (out_rd != '0);
  assign hz1 = op_rs1(r_op) && ((e_pend && (e_rd == r_rs1)) || (w_pend && (out_rd == r_rs1)));
  assign hz2 = op_rs2(r_op) && ((e_pend && (e_rd == r_rs2)) || (w_pend && (out_rd == r_rs2)));
  assign hazard = hz1 || hz2;
`endif

  assign in_ready = rdy_q && !rsum_hold && !hazard;
  assign accept   = in_valid && in_ready;

  // Operand read: W write is visible in the same cycle; register 0 always reads zero
  always_comb begin
    r_a = rf[r_rs1];
    r_b = rf[r_rs2];
    if (out_valid && (out_rd == r_rs1)) r_a = out_data;
    if (out_valid && (out_rd == r_rs2)) r_b = out_data;
`ifdef PSIMD_FWD_EN
    if (e_fin && e_we && (e_rd == r_rs1)) r_a = e_res;
    if (e_fin && e_we && (e_rd == r_rs2)) r_b = e_res;
`endif
    if (r_rs1 == '0) r_a = '0;
    if (r_rs2 == '0) r_b = '0;
  end

  // Lane-wise execute; RSUM accumulates one extra lane per E cycle
  always_comb begin
    e_res = '0;
    e_ovf = '0;
    for (int i = 0; i < LANES; i++) begin
      la[i] = e_a[i*LANE_W +: LANE_W];
      lb[i] = e_b[i*LANE_W +: LANE_W];
      sa[i] = {la[i][LANE_W-1], la[i]} + {lb[i][LANE_W-1], lb[i]};
      sd[i] = {la[i][LANE_W-1], la[i]} - {lb[i][LANE_W-1], lb[i]};
    end
    rs_idx = e_cnt + CW'(1);
    rs_sum = ((e_cnt == '0) ? la[0] : rs_acc) + la[rs_idx];
    for (int i = 0; i < LANES; i++) begin
      rl[i] = '0;
      case (e_op)
        OP_ADD:  rl[i] = sa[i][LANE_W-1:0];
        OP_ADDS: begin
          rl[i] = sa[i][LANE_W-1:0];
          if (sa[i][LANE_W] != sa[i][LANE_W-1]) begin
            rl[i]    = sa[i][LANE_W] ? SAT_MIN : SAT_MAX;
            e_ovf[i] = 1'b1;
          end
        end
        OP_SUB:  rl[i] = sd[i][LANE_W-1:0];
        OP_SUBS: begin
          rl[i] = sd[i][LANE_W-1:0];
          if (sd[i][LANE_W] != sd[i][LANE_W-1]) begin
            rl[i]    = sd[i][LANE_W] ? SAT_MIN : SAT_MAX;
            e_ovf[i] = 1'b1;
          end
        end
        OP_AND:  rl[i] = la[i] & lb[i];
        OP_OR:   rl[i] = la[i] | lb[i];
        OP_XOR:  rl[i] = la[i] ^ lb[i];
        OP_MIN:  rl[i] = ($signed(la[i]) < $signed(lb[i])) ? la[i] : lb[i];
        OP_MAX:  rl[i] = ($signed(la[i]) > $signed(lb[i])) ? la[i] : lb[i];
        OP_LDI:  rl[i] = LANE_W'(e_imm);
        OP_RSUM: rl[i] = (i == 0) ? rs_sum : '0;
        OP_NOP, OP_CLRF: rl[i] = '0;
        default: rl[i] = '0;
      endcase
      e_res[i*LANE_W +: LANE_W] = rl[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      rdy_q        <= 1'b0;
      e_valid      <= 1'b0;
      e_op         <= '0;
      e_rd         <= '0;
      e_a          <= '0;
      e_b          <= '0;
      e_imm        <= '0;
      e_cnt        <= '0;
      rs_acc       <= '0;
      w_clrf       <= 1'b0;
      out_valid    <= 1'b0;
      out_rd       <= '0;
      out_data     <= '0;
      ovf_flags    <= '0;
      illegal_flag <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rdy_q <= 1'b1;

      if (out_valid && (out_rd != '0)) rf[out_rd] <= out_data;

      if (rsum_hold) begin
        e_cnt  <= e_cnt + CW'(1);
        rs_acc <= rs_sum;
      end else begin
        e_valid <= accept;
        e_cnt   <= '0;
        if (accept) begin
          e_op  <= r_op;
          e_rd  <= r_rd;
          e_a   <= r_a;
          e_b   <= r_b;
          e_imm <= r_imm;
        end
      end

      // out_rd/out_data only move on a real writeback so they hold otherwise
      out_valid <= e_fin && e_we;
      if (e_fin && e_we) begin
        out_rd   <= e_rd;
        out_data <= e_res;
      end
      w_clrf <= e_fin && (e_op == OP_CLRF);

      // Sticky flags: a set from E beats a CLRF clear in W on the same edge
      ovf_flags    <= (ovf_flags & ~{LANES{w_clrf}}) | (e_valid ? e_ovf : '0);
      illegal_flag <= (illegal_flag && !w_clrf) || (e_valid && (e_op > OP_RSUM));

      busy <= e_valid || accept;
    end
  end

endmodule

// File: doc/psimd_lane_pipe.md
PSIMD_LANE_PIPE -- requirements
Module: psimd_lane_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4, number of 16-bit lanes (legal 2..8, power of two).
REQ-002 SHALL have parameter LANE_W, default 16, lane width in bits.
REQ-003 SHALL have parameter NREGS, default 32, vector register count; register addresses are 5 bits.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  instruction offered.
REQ-007 SHALL have port in_ready  output  1  instruction can be accepted.
REQ-008 SHALL have port instr  input  32  instruction: [31:28] opcode, [27:23] rd, [22:18] rs1, [17:13] rs2, [15:0] imm.
REQ-009 SHALL have port out_valid  output  1  one-cycle writeback strobe.
REQ-010 SHALL have port out_rd  output  5  destination of the current writeback.
REQ-011 SHALL have port out_data  output  LANES*LANE_W  written vector; lane i at bits [i*LANE_W +: LANE_W].
REQ-012 SHALL have port ovf_flags  output  LANES  sticky per-lane saturation flags.
REQ-013 SHALL have port illegal_flag  output  1  sticky flag for an undefined opcode.
REQ-014 SHALL have port busy  output  1  any instruction in flight or RSUM active.

Function
REQ-015 SHALL accept an instruction only on a cycle where in_valid and in_ready are both high.
REQ-016 SHALL run a 3-stage pipeline: read (R), execute (E), writeback (W); an instruction accepted in cycle N drives out_valid in cycle N+2 and updates the register in the same edge.
REQ-017 SHALL implement opcodes: 0 NOP, 1 ADD wrap, 2 ADDS signed saturate, 3 SUB wrap, 4 SUBS signed saturate, 5 AND, 6 OR, 7 XOR, 8 MIN signed, 9 MAX signed, 10 LDI, 11 CLRF, 12 RSUM.
REQ-018 SHALL, for ADDS/SUBS, clamp each lane to 0x7FFF or 0x8000 on overflow and set ovf_flags[i] for that lane.
REQ-019 SHALL, for LDI, broadcast imm to every lane of rd.
REQ-020 SHALL, for CLRF, clear ovf_flags and illegal_flag in its W cycle with no register write and out_valid low; a set event in the same cycle SHALL win.
REQ-021 SHALL, for RSUM, write the wrapping sum of all rs1 lanes to lane 0 of rd and zero the other lanes, spending LANES-1 cycles in E.
REQ-022 SHALL deassert in_ready for every cycle RSUM occupies E except its last.
REQ-023 SHALL treat opcodes 13-15 as NOP, set illegal_flag, and keep out_valid low.
REQ-024 SHALL keep out_valid low for NOP and CLRF.
REQ-025 SHALL hold out_rd and out_data at their last values while out_valid is low.
REQ-026 SHALL have no output backpressure; every writeback is a single-cycle strobe.
REQ-027 SHALL return the value written in the same edge when a register is read in R while W writes it (write-before-read).
REQ-028 SHALL ignore writes to rd 0 and return zero for reads of register 0.

Reset
REQ-029 SHALL, on rst high at a rising edge, clear all registers, pipeline valids, the RSUM counter, ovf_flags, and illegal_flag.
REQ-030 SHALL hold outputs in reset as: in_ready 0, out_valid 0, out_rd 0, out_data 0, busy 0.
REQ-031 SHALL drive in_ready 1 on the first cycle after rst falls.
REQ-032 SHALL discard in-flight instructions, including a partially completed RSUM, when rst is asserted mid-operation.

Configuration
REQ-033 SHALL, with macro PSIMD_FWD_EN defined, forward E and W results to R operands so dependent back-to-back instructions issue without stalls.
REQ-034 SHALL, without PSIMD_FWD_EN, hold in_ready low while rs1 or rs2 of the offered instruction matches a nonzero pending rd in E or W, adding up to 2 stall cycles.

Verification
REQ-035 SHALL check: LDI r1,0x0003; LDI r2,0x0004; ADD r3,r1,r2 back-to-back -> r3 lanes all 0x0007; with PSIMD_FWD_EN no stall cycles, without it 2 stall cycles.
REQ-036 SHALL check: r1=0x7FFF, r2=0x0001, ADDS r4 -> lanes 0x7FFF, ovf_flags 0xF; then CLRF -> ovf_flags 0x0.
REQ-037 SHALL check: r5 lanes {1,2,3,4}, RSUM r6,r5 -> out_data 0x0000_0000_0000_000A, in_ready low for 2 cycles (LANES=4).
REQ-038 SHALL check: opcode 14 -> illegal_flag 1, out_valid stays 0, no register changes.
REQ-039 SHALL check: rst asserted during RSUM -> busy 0, out_valid 0 next cycle, and the target register reads 0.
REQ-040 SHALL check: LDI r0,0x1234 then ADD r7,r0,r0 -> r7 lanes 0x0000.
